// File: rtl/seg_arb_pkg.sv
// Shared types and widths for the seven-segment display share arbiter.
// Optional inter-owner blanking gap is enabled by defining SEG_ARB_GAP_EN.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_e;

    localparam int SEG_DATA_W = 32;
    localparam int SEG_MASK_W = 8;

endpackage

// File: rtl/seg_share_arbiter_picker.sv
// Round-robin find-first: lowest offset from ptr among req bits not excluded.
// Purely combinational; the owner is excluded so rotation skips it.
module seg_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic               any,
    output logic [IW-1:0]      idx
);

    logic [NUM_REQ-1:0] cand;
    int                 j;

    assign cand = req & ~exclude;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && cand[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin time-share of one 8-digit seven-segment driver among NUM_REQ sources.
// Define SEG_ARB_GAP_EN to blank the display for GAP_CYCLES between owners.
module seg_share_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 200_000_000,
    parameter int GAP_CYCLES   = 10_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*SEG_DATA_W-1:0] req_data,
    input  logic [NUM_REQ*SEG_MASK_W-1:0] req_valid,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    owner_idx,
    output logic [SEG_DATA_W-1:0]         output_data,
    output logic [SEG_MASK_W-1:0]         output_valid
);

    localparam int IW = $clog2(NUM_REQ);
`ifdef SEG_ARB_GAP_EN
    localparam int CMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
`else
    localparam int CMAX = DWELL_CYCLES;
`endif
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
`ifdef SEG_ARB_GAP_EN
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
`endif

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SEG_DATA_W-1:0]  data_q, data_d;
    logic [SEG_MASK_W-1:0]  valid_q, valid_d;

    logic                   pick_any;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          ptr_next;
    logic [NUM_REQ-1:0]     gnt_pick;
    logic                   own_req;
    logic [SEG_DATA_W-1:0]  own_data;
    logic [SEG_MASK_W-1:0]  own_mask;
    logic                   take;
    logic                   leave;

    // gnt_q is zero outside SHOW, so excluding it is harmless there
    seg_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .exclude (gnt_q),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    assign gnt_pick = NUM_REQ'(1) << pick_idx;
    assign ptr_next = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign own_req  = |(req & gnt_q);

    always_comb begin
        own_data = '0;
        own_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IW'(i)) begin
                own_data = req_data[SEG_DATA_W*i +: SEG_DATA_W];
                own_mask = req_valid[SEG_MASK_W*i +: SEG_MASK_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        take    = 1'b0;
        leave   = 1'b0;
        unique case (state_q)
            IDLE: begin
                valid_d = '0;
                take    = pick_any;
            end
            SHOW: begin
                if (!own_req) begin
                    valid_d = '0;
                    leave   = 1'b1;
                end else begin
                    data_d  = own_data;
                    valid_d = own_mask;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (pick_any) begin
                        leave = 1'b1;
                    end else begin
                        cnt_d = DWELL_LD;
                    end
                end
            end
`ifdef SEG_ARB_GAP_EN
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pick_any) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (leave) begin
            if (!pick_any) begin
                state_d = IDLE;
                gnt_d   = '0;
            end else begin
`ifdef SEG_ARB_GAP_EN
                state_d = GAP;
                gnt_d   = '0;
                valid_d = '0;
                cnt_d   = GAP_LD;
`else
                take = 1'b1;
`endif
            end
        end
        if (take) begin
            state_d = SHOW;
            gnt_d   = gnt_pick;
            owner_d = pick_idx;
            ptr_d   = ptr_next;
            cnt_d   = DWELL_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign gnt          = gnt_q;
    assign owner_idx    = owner_q;
    assign output_data  = data_q;
    assign output_valid = valid_q;

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed table-driven bench for seg_share_arbiter, default build
// (NUM_REQ=4, DWELL_CYCLES=4, back-to-back owner switches).
module tb_seg_share_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [31:0]  req_valid;
    logic [3:0]   gnt;
    logic [1:0]   owner_idx;
    logic [31:0]  output_data;
    logic [7:0]   output_valid;

    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hB1B1_1111;
    localparam logic [31:0] D2 = 32'h2211_1711;
    localparam logic [31:0] D3 = 32'hD3D3_3333;
    localparam logic [7:0]  M0 = 8'h01;
    localparam logic [7:0]  M1 = 8'h03;
    localparam logic [7:0]  M2 = 8'hFF;
    localparam logic [7:0]  M3 = 8'h0F;

    seg_share_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (4),
        .GAP_CYCLES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .gnt          (gnt),
        .owner_idx    (owner_idx),
        .output_data  (output_data),
        .output_valid (output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        int          n;
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic [7:0]  val;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g,
                              input logic [1:0] o, input logic [7:0] v,
                              input logic [31:0] d);
        chk({tag, ".gnt"}, {28'b0, gnt}, {28'b0, g});
        chk({tag, ".owner"}, {30'b0, owner_idx}, {30'b0, o});
        chk({tag, ".valid"}, {24'b0, output_valid}, {24'b0, v});
        chk({tag, ".data"}, output_data, d);
        chk({tag, ".onehot0"}, {31'b0, $onehot0(gnt)}, 32'd1);
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        req_data  = {D3, D2, D1, D0};
        req_valid = {M3, M2, M1, M0};

        // reset with all requesting, then first grant
        tbl.push_back('{1'b1, 4'b1111, 2, 4'b0000, 2'd0, 8'h00, 32'h0});
        tbl.push_back('{1'b0, 4'b1111, 1, 4'b0001, 2'd0, 8'h00, 32'h0});
        tbl.push_back('{1'b1, 4'b0000, 1, 4'b0000, 2'd0, 8'h00, 32'h0});
        // single requester holds through expiry reloads
        tbl.push_back('{1'b0, 4'b0100, 1, 4'b0100, 2'd2, 8'h00, 32'h0});
        tbl.push_back('{1'b0, 4'b0100, 7, 4'b0100, 2'd2, M2, D2});
        // release coinciding with expiry, nobody else waiting
        tbl.push_back('{1'b0, 4'b0000, 3, 4'b0000, 2'd2, 8'h00, D2});
        tbl.push_back('{1'b1, 4'b0000, 1, 4'b0000, 2'd0, 8'h00, 32'h0});
        // three-way rotation
        tbl.push_back('{1'b0, 4'b1011, 1, 4'b0001, 2'd0, 8'h00, 32'h0});
        tbl.push_back('{1'b0, 4'b1011, 3, 4'b0001, 2'd0, M0, D0});
        tbl.push_back('{1'b0, 4'b1011, 1, 4'b0010, 2'd1, M0, D0});
        tbl.push_back('{1'b0, 4'b1011, 3, 4'b0010, 2'd1, M1, D1});
        tbl.push_back('{1'b0, 4'b1011, 1, 4'b1000, 2'd3, M1, D1});
        tbl.push_back('{1'b0, 4'b1011, 3, 4'b1000, 2'd3, M3, D3});
        tbl.push_back('{1'b0, 4'b1011, 1, 4'b0001, 2'd0, M3, D3});
        tbl.push_back('{1'b0, 4'b1011, 3, 4'b0001, 2'd0, M0, D0});
        // owner 1 releases early with req[3] waiting
        tbl.push_back('{1'b0, 4'b1011, 1, 4'b0010, 2'd1, M0, D0});
        tbl.push_back('{1'b0, 4'b1011, 1, 4'b0010, 2'd1, M1, D1});
        tbl.push_back('{1'b0, 4'b1001, 1, 4'b1000, 2'd3, 8'h00, D1});
        tbl.push_back('{1'b0, 4'b1001, 1, 4'b1000, 2'd3, M3, D3});
        // reset mid-SHOW clears the pointer
        tbl.push_back('{1'b1, 4'b1100, 1, 4'b0000, 2'd0, 8'h00, 32'h0});
        tbl.push_back('{1'b0, 4'b1100, 1, 4'b0100, 2'd2, 8'h00, 32'h0});
        tbl.push_back('{1'b0, 4'b1100, 1, 4'b0100, 2'd2, M2, D2});

        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].n; r++) begin
                step(tbl[k].rst, tbl[k].req);
                check_outs($sformatf("row%0d.%0d", k, r), tbl[k].gnt,
                           tbl[k].own, tbl[k].val, tbl[k].dat);
            end
        end

        // long hold by a lone requester: no grant change across many reloads
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        check_outs("hold.first", 4'b0010, 2'd1, 8'h00, 32'h0);
        for (int c = 0; c < 15; c++) begin
            step(1'b0, 4'b0010);
            check_outs($sformatf("hold.%0d", c), 4'b0010, 2'd1, M1, D1);
        end
        step(1'b0, 4'b0000);
        check_outs("hold.release", 4'b0000, 2'd1, 8'h00, D1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
